// File: rtl/als_stim_pkg.sv
// Shared types, constants and the LFSR step for the operand stream generator.
package als_stim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Galois taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;

   // Feedback polynomial of the result-compaction MISR
   localparam logic [32:0] MISR_POLY = 33'h0_0000_0065;

   // One step of the left-shifting Galois LFSR
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], 1'b0} ^ (s[31] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/als_misr.sv
// Multiple-input signature register: folds one data word per enabled cycle.
module als_misr
   import als_stim_pkg::*;
#(
   parameter int unsigned          WIDTH = 33,
   parameter logic [WIDTH-1:0]     POLY  = MISR_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Signature register; clear wins over fold so a restart never keeps old data.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ d;
      end
   end

endmodule

// File: rtl/als_operand_stream_gen.sv
// Pseudo-random operand-pair source for adder benchmarks, with a MISR over
// the returned results. The LFSRs are 32 bits wide, so WIDTH must not exceed 32.
module als_operand_stream_gen
   import als_stim_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter logic [31:0] NUM_VECTORS = 32'd1000000,
   parameter logic [31:0] SEED0       = 32'h0000_0001,
   parameter logic [31:0] SEED1       = 32'h0000_0002
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [WIDTH-1:0] in0,
   output logic [WIDTH-1:0] in1,
   input  logic [WIDTH:0]   res,
   output logic [WIDTH:0]   sig,
   output logic [31:0]      vec_count
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [31:0] SEED0_EFF = (SEED0 == 32'd0) ? 32'd1 : SEED0;
   localparam logic [31:0] SEED1_EFF = (SEED1 == 32'd0) ? 32'd1 : SEED1;
   localparam logic [WIDTH:0] POLY   = MISR_POLY[WIDTH:0];

   state_t      state, state_nxt;
   logic [31:0] lfsr_a, lfsr_b;
   logic        enter_run;
   logic        hs;
   logic        last;

   assign hs   = op_valid && op_ready;
   assign last = (vec_count == NUM_VECTORS - 32'd1);
   assign in0  = lfsr_a[WIDTH-1:0];
   assign in1  = lfsr_b[WIDTH-1:0];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and Moore outputs; start is only honoured outside RUN.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      op_valid  = 1'b0;
      enter_run = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               state_nxt = RUN;
               enter_run = 1'b1;
            end
         end
         RUN: begin
            busy     = 1'b1;
            op_valid = 1'b1;
            if (op_ready && last) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand LFSRs and accepted-pair counter: reload on run entry, step per handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_a    <= SEED0_EFF;
         lfsr_b    <= SEED1_EFF;
         vec_count <= '0;
      end else if (enter_run) begin
         lfsr_a    <= SEED0_EFF;
         lfsr_b    <= SEED1_EFF;
         vec_count <= '0;
      end else if (hs) begin
         lfsr_a    <= lfsr_next(lfsr_a);
         lfsr_b    <= lfsr_next(lfsr_b);
         vec_count <= vec_count + 32'd1;
      end
   end

   als_misr #(
      .WIDTH (WIDTH + 1),
      .POLY  (POLY)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (enter_run),
      .en  (hs),
      .d   (res),
      .q   (sig)
   );

endmodule

// File: tb/tb_als_operand_stream_gen.sv
// Self-checking bench: directed scenarios plus randomized stall/start runs,
// checked against per-vector expectation tables built from the stream rules.
module tb_als_operand_stream_gen;

   localparam int W = 32;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, op_ready;
   logic          busy, done, op_valid;
   logic [W-1:0]  in0, in1;
   logic [W:0]    res, sig;
   logic [31:0]   vec_count;
   logic [W:0]    res_noise = '0;

   logic          start1, ready1;
   logic          busy1, done1, op_valid1;
   logic [W-1:0]  in0_1, in1_1;
   logic [W:0]    res1, sig1;
   logic [31:0]   vec_count1;

   int passed = 0;
   int total  = 0;

   // Expected operands and signature indexed by number of accepted pairs.
   logic [31:0] ea [0:N];
   logic [31:0] eb [0:N];
   logic [W:0]  es [0:N];

   // Model of the run: accepted pairs, running flag, done flag.
   int cnt = 0;
   bit run = 0;
   bit dn  = 0;

   always #5 clk = ~clk;

   // Ideal adder; noise only corrupts res in cycles without a handshake.
   assign res  = ({1'b0, in0} + {1'b0, in1}) ^ res_noise;
   assign res1 = {1'b0, in0_1} + {1'b0, in1_1};

   als_operand_stream_gen #(
      .WIDTH(W), .NUM_VECTORS(32'd4), .SEED0(32'd1), .SEED1(32'd2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .op_valid(op_valid), .op_ready(op_ready), .in0(in0), .in1(in1),
      .res(res), .sig(sig), .vec_count(vec_count)
   );

   als_operand_stream_gen #(
      .WIDTH(W), .NUM_VECTORS(32'd1), .SEED0(32'd0), .SEED1(32'h8000_0000)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .op_valid(op_valid1), .op_ready(ready1), .in0(in0_1), .in1(in1_1),
      .res(res1), .sig(sig1), .vec_count(vec_count1)
   );

   // Multiply by x modulo x^32+x^22+x^2+x+1.
   function automatic logic [31:0] model_lfsr(input logic [31:0] s);
      logic [32:0] t;
      t = {s, 1'b0};
      if (t[32]) t = t ^ 33'h1_0040_0007;
      return t[31:0];
   endfunction

   // Multiply by x modulo the 33-bit MISR polynomial.
   function automatic logic [W:0] model_misr_shift(input logic [W:0] s);
      logic [W+1:0] t;
      t = {s, 1'b0};
      if (t[W+1]) t = t ^ {1'b1, 33'h0_0000_0065};
      return t[W:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all();
      check("busy",      {63'd0, busy},     {63'd0, run});
      check("done",      {63'd0, done},     {63'd0, dn});
      check("op_valid",  {63'd0, op_valid}, {63'd0, run});
      check("vec_count", {32'd0, vec_count}, 64'(cnt));
      check("in0",       {32'd0, in0},      {32'd0, ea[cnt]});
      check("in1",       {32'd0, in1},      {32'd0, eb[cnt]});
      check("sig",       {31'd0, sig},      {31'd0, es[cnt]});
   endtask

   // Drive one cycle of inputs, advance the model, clock, then check.
   task automatic step(input logic rdy, input logic st);
      op_ready  = rdy;
      start     = st;
      res_noise = rdy ? '0 : {$urandom(), 1'b1};
      if (run) begin
         if (rdy) begin
            cnt++;
            if (cnt == N) begin
               run = 0;
               dn  = 1;
            end
         end
      end else if (st) begin
         run = 1;
         dn  = 0;
         cnt = 0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ea[0] = 32'd1;
      eb[0] = 32'd2;
      es[0] = '0;
      for (int k = 0; k < N; k++) begin
         ea[k+1] = model_lfsr(ea[k]);
         eb[k+1] = model_lfsr(eb[k]);
         es[k+1] = model_misr_shift(es[k]) ^ ({1'b0, ea[k]} + {1'b0, eb[k]});
      end

      // Reset state of both instances.
      rst = 1'b1; start = 1'b0; op_ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();
      check("zero_seed_in0", {32'd0, in0_1}, 64'd1);
      check("seed1_in1",     {32'd0, in1_1}, 64'h8000_0000);

      // Full-throughput run: pairs (1,2),(2,4),(4,8),(8,16), done 5 edges after start.
      step(1, 1);
      for (int i = 0; i < N; i++) step(1, 0);
      step(0, 0);
      step(1, 0);

      // Restart from DONE with a 3-cycle stall after the first pair and a
      // stray start during RUN.
      step(1, 1);
      step(1, 0);
      for (int i = 0; i < 3; i++) step(0, 0);
      step(1, 1);
      step(1, 0);
      step(1, 0);
      check("stall_final_sig", {31'd0, sig}, 64'd0);

      // Asynchronous reset mid-run after two handshakes.
      step(1, 1);
      step(1, 0);
      step(1, 0);
      rst = 1'b1;
      #1;
      run = 0; dn = 0; cnt = 0;
      check("rst_busy",  {63'd0, busy}, 64'd0);
      check("rst_sig",   {31'd0, sig}, 64'd0);
      check("rst_count", {32'd0, vec_count}, 64'd0);
      // start coincident with reset: reset wins.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      check_all();
      step(1, 1);
      for (int i = 0; i < N; i++) step(1, 0);

      // Single-vector instance with zero seed substitution.
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      ready1 = 1'b1;
      check("nv1_busy",  {63'd0, busy1}, 64'd1);
      check("nv1_in0",   {32'd0, in0_1}, 64'd1);
      @(posedge clk);
      #1;
      ready1 = 1'b0;
      check("nv1_done",  {63'd0, done1}, 64'd1);
      check("nv1_busy0", {63'd0, busy1}, 64'd0);
      check("nv1_count", {32'd0, vec_count1}, 64'd1);
      check("nv1_in0_2", {32'd0, in0_1}, 64'd2);
      check("nv1_taps",  {32'd0, in1_1}, 64'h0040_0007);
      check("nv1_sig",   {31'd0, sig1}, 64'h0_8000_0001);

      // Randomized stalls and stray start pulses.
      for (int r = 0; r < 8; r++) begin
         step(1, 1);
         for (int i = 0; i < 300 && run; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
         check("rand_done", {63'd0, done}, 64'd1);
         for (int i = 0; i < int'($urandom_range(0, 3)); i++)
            step(1'($urandom_range(0, 1)), 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
